axil_reg_slave: RTL and testbench

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

---
 rtl/axil_reg_slave_if.sv | 34 +++
 rtl/axil_reg_slave.sv | 166 ++++++++++++++++
 tb/tb_axil_reg_slave.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite channel bundle for axil_reg_slave: AW, W, B, AR and R signals
// with master and slave views.
interface axil_reg_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS byte-strobed registers with independent
// read and write state machines and all handshake outputs registered.
module axil_reg_slave #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axil_reg_slave_if.slave              bus,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    // One extra bit so the span compare stays valid for narrow ADDR_W.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_REGS * STRB_W);

    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}                     rstate_t;

    wstate_t             w_state;
    rstate_t             r_state;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    logic                aw_hs, w_hs, ar_hs, commit_en;
    logic [ADDR_W-1:0]   commit_addr;
    logic [DATA_W-1:0]   commit_data;
    logic [STRB_W-1:0]   commit_strb;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] a);
        return a[LANE_W +: IDX_W];
    endfunction

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // The commit takes whichever half arrived earlier from the latches.
    always_comb begin
        aw_hs       = bus.awvalid & bus.awready;
        w_hs        = bus.wvalid  & bus.wready;
        ar_hs       = bus.arvalid & bus.arready;
        commit_addr = (w_state == W_GOT_AW) ? aw_addr_q : bus.awaddr;
        commit_data = (w_state == W_GOT_W)  ? wdata_q   : bus.wdata;
        commit_strb = (w_state == W_GOT_W)  ? wstrb_q   : bus.wstrb;
        commit_en   = ((w_state == W_IDLE)   & aw_hs & w_hs) |
                      ((w_state == W_GOT_AW) & w_hs) |
                      ((w_state == W_GOT_W)  & aw_hs);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            aw_addr_q   <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit_en) begin
            w_state     <= W_RESP;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b1;
            if (in_range(commit_addr)) begin
                regs[reg_idx(commit_addr)] <= merge_lanes(regs[reg_idx(commit_addr)],
                                                          commit_data, commit_strb);
                bus.bresp <= 2'b00;
            end else begin
                bus.bresp <= 2'b10;
            end
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q   <= bus.awaddr;
                        w_state     <= W_GOT_AW;
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b1;
                    end else if (w_hs) begin
                        wdata_q     <= bus.wdata;
                        wstrb_q     <= bus.wstrb;
                        w_state     <= W_GOT_W;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b0;
                    end else begin
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                    end
                end
                W_GOT_AW, W_GOT_W: ;
                W_RESP: begin
                    if (bus.bready) begin
                        w_state     <= W_IDLE;
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read data is sampled from regs before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state     <= R_DATA;
                        bus.arready <= 1'b0;
                        bus.rvalid  <= 1'b1;
                        if (in_range(bus.araddr)) begin
                            bus.rdata <= regs[reg_idx(bus.araddr)];
                            bus.rresp <= 2'b00;
                        end else begin
                            bus.rdata <= '0;
                            bus.rresp <= 2'b10;
                        end
                    end else begin
                        bus.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        r_state     <= R_IDLE;
                        bus.rvalid  <= 1'b0;
                        bus.arready <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs[i];
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomised bench for axil_reg_slave against an array-based register model,
// plus directed cases for strobes, out-of-range, backpressure and reset.
module tb_axil_reg_slave;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;

    typedef logic [255:0] val_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_REGS*DATA_W-1:0] regs_o;

    axil_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axil_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .regs_o (regs_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] model [NUM_REGS];

    task automatic chk(input string tag, input val_t obs, input val_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic val_t model_flat();
        val_t f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return a < 32'(NUM_REGS * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n;
        n = 0;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("aw_timeout", val_t'(0), val_t'(1));
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("w_timeout", val_t'(0), val_t'(1));
        tick();
        bus.wvalid = 1'b0;
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first; gap idle cycles between.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap, input int hold);
        logic [1:0] exp_resp;
        int n;
        if (mode == 0) begin
            n = 0;
            bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
            bus.awvalid = 1'b1; bus.wvalid = 1'b1;
            while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
            if (n >= 20) chk("aww_timeout", val_t'(0), val_t'(1));
            tick();
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        end else if (mode == 1) begin
            send_aw(a);
            chk("awready_after_aw", val_t'(bus.awready), val_t'(0));
            repeat (gap) begin
                tick();
                chk("wready_in_gap", val_t'(bus.wready), val_t'(1));
            end
            send_w(d, s);
        end else begin
            send_w(d, s);
            chk("wready_after_w", val_t'(bus.wready), val_t'(0));
            repeat (gap) begin
                tick();
                chk("awready_in_gap", val_t'(bus.awready), val_t'(1));
            end
            send_aw(a);
        end
        exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
        if (addr_ok(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a / 4][8*b +: 8] = d[8*b +: 8];
        end
        chk("bvalid", val_t'(bus.bvalid), val_t'(1));
        chk("bresp", val_t'(bus.bresp), val_t'(exp_resp));
        chk("regs_o_wr", val_t'(regs_o), model_flat());
        repeat (hold) begin
            tick();
            chk("bvalid_hold", val_t'(bus.bvalid), val_t'(1));
            chk("bresp_hold", val_t'(bus.bresp), val_t'(exp_resp));
            chk("aw_w_ready_hold", val_t'({bus.awready, bus.wready}), val_t'(0));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bvalid_drop", val_t'(bus.bvalid), val_t'(0));
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int n;
        exp_d = addr_ok(a) ? model[a / 4] : 32'h0;
        exp_r = addr_ok(a) ? 2'b00 : 2'b10;
        n = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("ar_timeout", val_t'(0), val_t'(1));
        tick();
        bus.arvalid = 1'b0;
        chk("rvalid", val_t'(bus.rvalid), val_t'(1));
        chk("rdata", val_t'(bus.rdata), val_t'(exp_d));
        chk("rresp", val_t'(bus.rresp), val_t'(exp_r));
        repeat (hold) begin
            tick();
            chk("rvalid_hold", val_t'(bus.rvalid), val_t'(1));
            chk("rdata_hold", val_t'(bus.rdata), val_t'(exp_d));
            chk("rresp_hold", val_t'(bus.rresp), val_t'(exp_r));
            chk("arready_hold", val_t'(bus.arready), val_t'(0));
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("rvalid_drop", val_t'(bus.rvalid), val_t'(0));
        chk("arready_back", val_t'(bus.arready), val_t'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, val_t'({bus.awready, bus.wready, bus.arready}), val_t'(0));
        chk({tag, "_valid"}, val_t'({bus.bvalid, bus.rvalid}), val_t'(0));
        chk({tag, "_resp"}, val_t'({bus.bresp, bus.rresp}), val_t'(0));
        chk({tag, "_rdata"}, val_t'(bus.rdata), val_t'(0));
        chk({tag, "_regs_o"}, val_t'(regs_o), val_t'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;

        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", val_t'({bus.awready, bus.wready, bus.arready}), val_t'(3'b111));

        // Same-edge AW/W, then read back.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h04, 0);
        chk("req036_value", val_t'(regs_o[63:32]), val_t'(32'hDEADBEEF));

        // Partial strobe, W two cycles ahead of AW.
        do_write(32'h08, 32'hAAAAAAAA, 4'hF, 0, 0, 0);
        do_write(32'h08, 32'h12345678, 4'h3, 2, 2, 0);
        chk("req037_value", val_t'(regs_o[95:64]), val_t'(32'hAAAA5678));

        // Out of range, strobe zero, backpressure.
        do_write(32'h20, 32'h01020304, 4'hF, 0, 0, 0);
        do_read(32'h20, 0);
        do_write(32'h08, 32'hFFFFFFFF, 4'h0, 1, 1, 0);
        do_write(32'h1C, 32'hC0FFEE01, 4'hF, 1, 1, 5);
        do_read(32'h1C, 5);

        // Read and write commit on the same edge to the same register.
        do_write(32'h0C, 32'h11, 4'hF, 0, 0, 0);
        bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.araddr = 32'h0C;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        chk("conc_ready", val_t'({bus.awready, bus.wready, bus.arready}), val_t'(3'b111));
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("conc_rdata_old", val_t'(bus.rdata), val_t'(32'h11));
        chk("conc_valids", val_t'({bus.bvalid, bus.rvalid}), val_t'(2'b11));
        model[3] = 32'h55;
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        chk("conc_done", val_t'({bus.bvalid, bus.rvalid}), val_t'(0));
        do_read(32'h0C, 0);

        // Reset in the middle of W_GOT_AW and R_DATA.
        do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        bus.awaddr = 32'h14; bus.awvalid = 1'b1;
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        chk("pre_rst_rdata", val_t'(bus.rdata), val_t'(32'hCAFEF00D));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        chk_all_zero("midrst");
        tick();
        chk("ready_after_midrst", val_t'({bus.awready, bus.wready, bus.arready}), val_t'(3'b111));
        do_write(32'h14, 32'h0BADCAFE, 4'hF, 0, 0, 0);
        do_read(32'h10, 0);
        do_read(32'h14, 0);

        // Random traffic against the model.
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 3)));
        end
        chk("final_regs", val_t'(regs_o), model_flat());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
